// File: rtl/instr_fetch_responder_pkg.sv
// Shared fetch-path definitions: FSM state encoding and the NOP instruction word.
// The decoder imports NOP_WORD so an aborted fetch is decoded as a no-op.
package instr_fetch_responder_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DELIVER = 2'd2
    } fetchState_t;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch_responder.sv
// Fetch responder between the PC and instruction memory: one req/ack read per PC value,
// holding the PC (stall=1) in every cycle that does not deliver an instruction.
module instr_fetch_responder
    import instr_fetch_responder_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 256,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] adressIn,
    input  logic                  halt,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] instruction,
    output logic                  instr_valid,
    output logic                  stall,
    output logic                  fault,
    output fetchState_t           debugState
);

    // One extra bit keeps TIMEOUT-1 representable for any TIMEOUT >= 1.
    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    // Memory handshake: mem_req rises and mem_addr is captured on the launch edge;
    // both stay stable until the edge that samples mem_ack=1 or hits the timeout.
    fetchState_t           state, stateNext;
    logic                  reqNext, validNext, stallNext, faultNext;
    logic [ADDR_WIDTH-1:0] addrNext;
    logic [DATA_WIDTH-1:0] instrNext;
    logic [CNT_W-1:0]      waitCnt, waitCntNext;

    assign debugState = state;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            instruction <= DATA_WIDTH'(NOP_WORD);
            instr_valid <= 1'b0;
            stall       <= 1'b1;
            fault       <= 1'b0;
            waitCnt     <= '0;
        end else begin
            state       <= stateNext;
            mem_req     <= reqNext;
            mem_addr    <= addrNext;
            instruction <= instrNext;
            instr_valid <= validNext;
            stall       <= stallNext;
            fault       <= faultNext;
            waitCnt     <= waitCntNext;
        end
    end

    always_comb begin
        stateNext   = state;
        reqNext     = mem_req;
        addrNext    = mem_addr;
        instrNext   = instruction;
        validNext   = 1'b0;
        stallNext   = 1'b1;
        faultNext   = 1'b0;
        waitCntNext = waitCnt;
        case (state)
            IDLE: begin
                if (!halt) begin
                    if (adressIn < ADDR_WIDTH'(DEPTH)) begin
                        addrNext    = adressIn;
                        reqNext     = 1'b1;
                        waitCntNext = '0;
                        stateNext   = WAIT;
                    end else begin
                        instrNext = DATA_WIDTH'(NOP_WORD);
                        validNext = 1'b1;
                        faultNext = 1'b1;
                        stallNext = 1'b0;
                        stateNext = DELIVER;
                    end
                end
            end
            WAIT: begin
                // An ack on the timeout cycle still delivers real data.
                if (mem_ack) begin
                    instrNext = mem_rdata;
                    validNext = 1'b1;
                    stallNext = 1'b0;
                    reqNext   = 1'b0;
                    stateNext = DELIVER;
                end else if (waitCnt == CNT_W'(TIMEOUT - 1)) begin
                    reqNext   = 1'b0;
                    instrNext = DATA_WIDTH'(NOP_WORD);
                    validNext = 1'b1;
                    faultNext = 1'b1;
                    stallNext = 1'b0;
                    stateNext = DELIVER;
                end else begin
                    waitCntNext = waitCnt + CNT_W'(1);
                end
            end
            DELIVER: begin
                stateNext = IDLE;
            end
            default: begin
                reqNext   = 1'b0;
                stateNext = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_instr_fetch_responder.sv
// Directed bench for instr_fetch_responder: in-range, delayed, timeout, out-of-range,
// halt and mid-fetch reset scenarios with hand-computed expectations.
module tb_instr_fetch_responder;
    import instr_fetch_responder_pkg::*;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 32;
    localparam int DEPTH      = 256;
    localparam int TIMEOUT    = 15;

    logic                  clock;
    logic                  reset;
    logic [ADDR_WIDTH-1:0] adressIn;
    logic                  halt;
    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_ack;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic [DATA_WIDTH-1:0] instruction;
    logic                  instr_valid;
    logic                  stall;
    logic                  fault;
    fetchState_t           debugState;

    int assertCount = 0;
    int failCount   = 0;

    instr_fetch_responder #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .DEPTH     (DEPTH),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .adressIn   (adressIn),
        .halt       (halt),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .instruction(instruction),
        .instr_valid(instr_valid),
        .stall      (stall),
        .fault      (fault),
        .debugState (debugState)
    );

    // Clock and reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkValue(input string tag, input logic [63:0] got, input logic [63:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Launches one fetch from IDLE with halt=1 beforehand; halt is raised again right after
    // the launch edge so the block must finish the fetch and then stay idle.
    // ackDelay=0 means memory never acks.
    task automatic doFetch(input string tag, input logic [ADDR_WIDTH-1:0] addr,
                           input int ackDelay, input logic [DATA_WIDTH-1:0] data);
        int  deliveredAt;
        bit  reqHeldOk;
        bit  inRange;
        logic [DATA_WIDTH-1:0] expInstr;
        bit  expFault;
        int  expEdge;
        inRange     = (addr < DEPTH);
        deliveredAt = -1;
        reqHeldOk   = 1'b1;
        adressIn = addr;
        halt     = 1'b0;
        tick();
        halt     = 1'b1;
        if (!inRange) begin
            checkValue({tag, "_oor_req"},   mem_req, 0);
            checkValue({tag, "_oor_valid"}, instr_valid, 1);
            checkValue({tag, "_oor_fault"}, fault, 1);
            checkValue({tag, "_oor_instr"}, instruction, 0);
            checkValue({tag, "_oor_stall"}, stall, 0);
        end else begin
            checkValue({tag, "_launch_req"},   mem_req, 1);
            checkValue({tag, "_launch_addr"},  mem_addr, addr);
            checkValue({tag, "_launch_stall"}, stall, 1);
            adressIn = addr ^ 32'h0000_0033;
            for (int c = 1; c <= 40; c++) begin
                if (ackDelay == c) begin
                    mem_ack   = 1'b1;
                    mem_rdata = data;
                end
                tick();
                mem_ack   = 1'b0;
                mem_rdata = 32'hDEAD_BEEF;
                if (instr_valid) begin
                    deliveredAt = c;
                    break;
                end
                if (!(mem_req === 1'b1 && mem_addr === addr && stall === 1'b1)) reqHeldOk = 1'b0;
            end
            expFault = (ackDelay == 0 || ackDelay > TIMEOUT);
            expEdge  = expFault ? TIMEOUT : ackDelay;
            expInstr = expFault ? 32'h0 : data;
            checkValue({tag, "_req_held"},   reqHeldOk, 1);
            checkValue({tag, "_latency"},    deliveredAt, expEdge);
            checkValue({tag, "_instr"},      instruction, expInstr);
            checkValue({tag, "_fault"},      fault, expFault);
            checkValue({tag, "_stall_low"},  stall, 0);
            checkValue({tag, "_req_drop"},   mem_req, 0);
        end
        tick();
        checkValue({tag, "_valid_end"}, instr_valid, 0);
        checkValue({tag, "_fault_end"}, fault, 0);
        checkValue({tag, "_stall_end"}, stall, 1);
        tick();
        checkValue({tag, "_idle_req"},   mem_req, 0);
        checkValue({tag, "_idle_state"}, debugState, IDLE);
        checkValue({tag, "_instr_hold"}, instruction, inRange ? ((ackDelay == 0 || ackDelay > TIMEOUT) ? 32'h0 : data) : 32'h0);
    endtask

    initial begin
        bit idleOk;
        reset     = 1'b0;
        halt      = 1'b1;
        adressIn  = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        tick();
        tick();
        checkValue("rst_req",   mem_req, 0);
        checkValue("rst_addr",  mem_addr, 0);
        checkValue("rst_instr", instruction, 0);
        checkValue("rst_valid", instr_valid, 0);
        checkValue("rst_stall", stall, 1);
        checkValue("rst_fault", fault, 0);
        checkValue("rst_state", debugState, IDLE);
        reset = 1'b1;
        tick();

        doFetch("ack1",    32'd0,   1,  32'h2001_0005);
        doFetch("ack3",    32'd5,   3,  32'hA5A5_1234);
        doFetch("timeout", 32'd9,   0,  32'h1111_1111);
        doFetch("ack_tie", 32'd12,  TIMEOUT, 32'h0BAD_F00D);
        doFetch("ack14",   32'd255, 14, 32'h7654_3210);
        doFetch("oor256",  32'd256, 0,  32'h0);
        doFetch("ack2",    32'd77,  2,  32'hCAFE_0001);
        doFetch("oor300",  32'd300, 0,  32'h0);

        // Halted in IDLE: nothing launched, PC held; stray acks ignored.
        idleOk = 1'b1;
        for (int i = 0; i < 10; i++) begin
            mem_ack   = (i == 4);
            mem_rdata = 32'h5555_AAAA;
            tick();
            if (!(mem_req === 1'b0 && stall === 1'b1 && instr_valid === 1'b0)) idleOk = 1'b0;
        end
        mem_ack = 1'b0;
        checkValue("halt_idle", idleOk, 1);
        checkValue("halt_instr_hold", instruction, 0);

        // Reset in the middle of a wait, then a stray ack after release.
        adressIn = 32'd7;
        halt     = 1'b0;
        tick();
        halt     = 1'b1;
        checkValue("mid_launch_req", mem_req, 1);
        tick();
        tick();
        reset = 1'b0;
        #1;
        checkValue("mid_rst_req",   mem_req, 0);
        checkValue("mid_rst_stall", stall, 1);
        checkValue("mid_rst_valid", instr_valid, 0);
        checkValue("mid_rst_addr",  mem_addr, 0);
        checkValue("mid_rst_state", debugState, IDLE);
        tick();
        reset = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 32'h9999_9999;
        tick();
        mem_ack = 1'b0;
        checkValue("stray_valid", instr_valid, 0);
        checkValue("stray_instr", instruction, 0);
        checkValue("stray_req",   mem_req, 0);
        checkValue("stray_stall", stall, 1);
        tick();
        checkValue("stray_state", debugState, IDLE);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/instr_fetch_responder.md
Name: instr_fetch_responder

Overview:
- Serves the instruction addresses issued by the program counter: latches the address, runs a req/ack read on the instruction memory port, and returns the instruction word.
- Drives the PC's hold input (stall) high for every cycle in which no instruction is being delivered, so the PC advances exactly once per completed fetch.
- Sits between the PC and instruction memory, feeding the decoder.

Parameters:
- DATA_WIDTH, 32, instruction word width.
- ADDR_WIDTH, 32, address width (PC output width).
- DEPTH, 256, number of valid instruction words; addresses >= DEPTH are out of range.
- TIMEOUT, 15, maximum cycles to wait for mem_ack before aborting (>= 1).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- adressIn  in  ADDR_WIDTH  current PC value.
- halt  in  1  processor halted; no new fetch is launched.
- mem_req  out  1  read request to instruction memory.
- mem_addr  out  ADDR_WIDTH  read address, stable while mem_req=1.
- mem_ack  in  1  memory read-data valid, single-cycle pulse.
- mem_rdata  in  DATA_WIDTH  read data, sampled when mem_ack=1.
- instruction  out  DATA_WIDTH  fetched word to the decoder.
- instr_valid  out  1  one-cycle pulse: instruction is new.
- stall  out  1  to the PC hold input; 1 = PC holds.
- fault  out  1  one-cycle pulse: timeout or out-of-range abort.

Behaviour:
Clock and reset:
- One clock. Reset asserted (0) asynchronously clears everything; it is released synchronously by the surrounding logic.
- Reset values: state=IDLE, mem_req=0, mem_addr=0, instruction=0 (NOP), instr_valid=0, stall=1, fault=0, wait counter=0.

State machine (IDLE, WAIT, DELIVER):
- IDLE:
  - halt=1: remain in IDLE, stall=1.
  - halt=0 and adressIn < DEPTH: on the edge, mem_addr<=adressIn, mem_req<=1, counter<=0, go to WAIT.
  - halt=0 and adressIn >= DEPTH: no request; instruction<=0, instr_valid<=1, fault<=1, stall<=0, go to DELIVER.
- WAIT:
  - mem_req stays 1 and mem_addr stays stable until termination; halt is ignored here.
  - mem_ack=1 sampled: instruction<=mem_rdata, instr_valid<=1, stall<=0, mem_req<=0, go to DELIVER.
  - Otherwise the counter increments. If the counter equals TIMEOUT-1 with no ack: mem_req<=0, instruction<=0, instr_valid<=1, fault<=1, stall<=0, go to DELIVER.
  - An ack in the same cycle as the timeout wins; no fault is raised.
- DELIVER:
  - Lasts exactly one cycle; the PC advances at the closing edge.
  - On that edge: instr_valid<=0, fault<=0, stall<=1, go to IDLE.

Timing and protocol rules:
- Fetch latency: the request is launched one edge after IDLE. With an ack k cycles after mem_req rises (k>=1), instr_valid rises k edges after mem_req. The minimum loop is 3 cycles per instruction.
- mem_ack outside WAIT is ignored. mem_rdata is sampled only when mem_ack=1.
- adressIn is sampled only at the IDLE launch edge. Changes to adressIn during WAIT are ignored.
- instruction holds its last value between deliveries.
- Reset mid-transaction drops mem_req immediately. An ack arriving after reset is ignored.
- Counter width is clog2(TIMEOUT)+1; the counter never wraps.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, WAIT=2'd1, DELIVER=2'd2) and the NOP word constant (32'h0000_0000), reused by the decoder.
- No sub-module required. The timeout counter stays inline.

Test Plan:
- Reset then release, halt=0, adressIn=0, memory acks 1 cycle after req with 32'h2001_0005 -> mem_addr=0. Then instr_valid and stall=0 for one cycle, instruction=32'h2001_0005, then stall returns to 1.
- Ack delayed 3 cycles, adressIn=5 -> mem_req held 3 cycles with mem_addr=5 stable, exactly one instr_valid pulse, fault=0.
- No ack, TIMEOUT=15 -> mem_req drops after 15 cycles, then instruction=0, fault=1 and instr_valid=1 in the same cycle, stall=0 for one cycle.
- adressIn=300, DEPTH=256 -> mem_req never rises, fault=1 with instruction=0 one edge after IDLE.
- halt=1 in IDLE -> no mem_req for 10 cycles, stall=1 throughout. halt raised during WAIT -> the fetch still completes and delivers, then the block stays in IDLE.
- reset driven to 0 mid-WAIT, then a stray mem_ack -> mem_req=0 and stall=1 immediately, no instr_valid, outputs at reset values.
